// File: rtl/gf_inv_4_masked_pipe.sv
// -----------------------------------------------------------------------------
// gf_inv_4_masked_pipe
//
// Pipelined, multi-lane, first-order Boolean-masked inverter in GF(2^4) built
// over GF(2^2), normal basis [alpha^8, alpha^2] (Canright tower, nu = W^2).
// Per lane the block takes a masked operand A with input mask M and a fresh
// output mask N, and returns Q with Q ^ N = inv(A ^ M), where inv(0) = 0.
//
// The mask-sensitive partial-sum chains are cut across three register stages
// (S1, S2, S3), so the order in which mask terms are summed is fixed by flops
// rather than by gate ordering. All lanes share one valid/ready control path.
//
// Parameters
//   LANES         number of independent 4-bit inverters (>= 1)
//   CLEAR_ON_IDLE 1: stage data is zeroed when a bubble moves into the stage
//                 0: stage data holds its last value across bubbles
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   A/M/N beat is valid
//   in_ready   block accepts a beat this cycle (= pipeline advance enable)
//   A          masked operands, lane i on A[4i+3:4i]
//   M          input masks, A ^ M is the unmasked operand
//   N          fresh output masks, independent of M
//   out_valid  Q holds a valid result
//   out_ready  downstream accepts Q
//   Q          masked results, Q ^ N = inv(A ^ M) per lane
//   busy       at least one stage holds a valid beat
// -----------------------------------------------------------------------------
module gf_inv_4_masked_pipe #(
    parameter int unsigned LANES         = 1,
    parameter bit          CLEAR_ON_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   A,
    input  logic [4*LANES-1:0]   M,
    input  logic [4*LANES-1:0]   N,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   Q,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Per-lane stage payloads
    // ------------------------------------------------------------------

    // S1 holds the first-level products plus the masked operand halves,
    // their masks and the full output mask for later stages.
    typedef struct packed {
        logic [1:0] cst;   // NOR/NAND norm term, already covered by N[3:2]
        logic [1:0] an;    // a * n
        logic [1:0] mb;    // m * b
        logic [1:0] mn;    // m * n
        logic [1:0] a;     // masked high half
        logic [1:0] b;     // masked low half
        logic [1:0] m;     // mask of a
        logic [1:0] n;     // mask of b
        logic [3:0] nm;    // fresh output mask N
    } s1_lane_t;

    // S2 holds the masked GF(2^2) inverse and the output-mask-led partial sums.
    typedef struct packed {
        logic [1:0] e;     // inverse of the norm, masked by n
        logic [1:0] qsa;   // N[1:0] ^ a*n
        logic [1:0] psa;   // N[3:2] ^ m*b
        logic [1:0] mn;    // m * n
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] m;
        logic [1:0] n;
    } s2_lane_t;

    localparam int unsigned S1_W = $bits(s1_lane_t);
    localparam int unsigned S2_W = $bits(s2_lane_t);

    // ------------------------------------------------------------------
    // GF(2^2) helpers, normal basis [W^2, W]
    // ------------------------------------------------------------------

    // GF(2^2) multiply with the shared (x1^x0)(y1^y0) factor.
    function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y);
        logic s;
        s = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ s, (x[0] & y[0]) ^ s};
    endfunction

    // Norm of the masked halves: a*b ^ nu*(a^b)^2, in Canright's NOR/NAND form.
    // Operates on masked values only; a^b of two masked halves never removes a mask.
    function automatic logic [1:0] nor_nand_term(input logic [1:0] a, input logic [1:0] b);
        logic sa;
        logic sb;
        sa = a[1] ^ a[0];
        sb = b[1] ^ b[0];
        return {(~(a[1] | b[1])) ^ (~(sa & sb)), (~(sa | sb)) ^ (~(a[0] & b[0]))};
    endfunction

    // Mask-only correction for the norm: nu*(m^n)^2 ^ swap(n).
    // The nu*(m^n)^2 part cancels the mask contribution of the square term;
    // the swap(n) part leaves c masked by swap(n), so the bit-swap inverse
    // hands out e masked by exactly n.
    function automatic logic [1:0] mask_fold(input logic [1:0] m, input logic [1:0] n);
        return {m[1] ^ n[1] ^ n[0], m[0] ^ n[0] ^ m[1]};
    endfunction

    // ------------------------------------------------------------------
    // Stage datapaths (one lane each)
    // ------------------------------------------------------------------

    // S1: split operands and form the factored first-level products.
    function automatic s1_lane_t stage1_calc(input logic [3:0] a_in,
                                             input logic [3:0] m_in,
                                             input logic [3:0] n_in);
        s1_lane_t r;
        r.a   = a_in[3:2];
        r.b   = a_in[1:0];
        r.m   = m_in[3:2];
        r.n   = m_in[1:0];
        r.nm  = n_in;
        r.an  = gf2_mul(r.a, r.n);
        r.mb  = gf2_mul(r.m, r.b);
        r.mn  = gf2_mul(r.m, r.n);
        r.cst = n_in[3:2] ^ nor_nand_term(r.a, r.b);
        return r;
    endfunction

    // S2: ordered norm summation, GF(2^2) inverse, and output-mask-led sums.
    // N[3:2] enters the chain through cst and leaves again through cm, so
    // every partial sum stays covered until the final term is added.
    function automatic s2_lane_t stage2_calc(input s1_lane_t s);
        s2_lane_t   r;
        logic [1:0] cm;
        logic [1:0] csa;
        logic [1:0] csb;
        logic [1:0] c;
        cm    = s.nm[3:2] ^ s.mn ^ mask_fold(s.m, s.n);
        csa   = s.cst ^ s.an;
        csb   = csa ^ s.mb;
        c     = csb ^ cm;
        r.e   = {c[0], c[1]};          // inverse in GF(2^2) is a bit swap
        r.qsa = s.nm[1:0] ^ s.an;
        r.psa = s.nm[3:2] ^ s.mb;
        r.mn  = s.mn;
        r.a   = s.a;
        r.b   = s.b;
        r.m   = s.m;
        r.n   = s.n;
        return r;
    endfunction

    // S3: output products and the final mask-ordered sums.
    function automatic logic [3:0] stage3_calc(input s2_lane_t s);
        logic [1:0] q;
        logic [1:0] em;
        logic [1:0] mask_sw;
        logic [1:0] d;
        logic [1:0] p;
        logic [1:0] dn;
        logic [1:0] qm;
        logic [1:0] pm;
        q       = gf2_mul(s.e, s.a);
        em      = gf2_mul(s.e, s.m);
        mask_sw = s.m ^ s.n;           // mask-only value
        d       = s.e ^ mask_sw;       // inverse now masked by m instead of n
        p       = gf2_mul(d, s.b);
        dn      = gf2_mul(d, s.n);
        qm      = (s.qsa ^ em) ^ s.mn;
        pm      = (s.psa ^ dn) ^ s.mn;
        return {pm ^ p, qm ^ q};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------

    logic                  s1_v_q;
    logic                  s1_v_d;
    logic                  s2_v_q;
    logic                  s2_v_d;
    logic                  s3_v_q;
    logic                  s3_v_d;

    s1_lane_t [LANES-1:0]  s1_q;
    s1_lane_t [LANES-1:0]  s1_d;
    s1_lane_t [LANES-1:0]  s1_calc_s;
    s2_lane_t [LANES-1:0]  s2_q;
    s2_lane_t [LANES-1:0]  s2_d;
    s2_lane_t [LANES-1:0]  s2_calc_s;
    logic [LANES-1:0][3:0] s3_q;
    logic [LANES-1:0][3:0] s3_d;
    logic [LANES-1:0][3:0] s3_calc_s;

    logic                  en_s;

    // Whole pipe advances unless a valid output is being held back.
    assign en_s = (~s3_v_q) | out_ready;

    // Per-lane combinational logic feeding each stage register.
    always_comb begin
        s1_calc_s = {(LANES*S1_W){1'b0}};
        s2_calc_s = {(LANES*S2_W){1'b0}};
        s3_calc_s = {(LANES*4){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            s1_calc_s[i] = stage1_calc(A[4*i +: 4], M[4*i +: 4], N[4*i +: 4]);
            s2_calc_s[i] = stage2_calc(s1_q[i]);
            s3_calc_s[i] = stage3_calc(s2_q[i]);
        end
    end

    // Next-state selection: shift on advance, hold on stall, optional bubble clear.
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        s3_v_d = s3_v_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        s3_d   = s3_q;
        if (en_s) begin
            s1_v_d = in_valid;
            s2_v_d = s1_v_q;
            s3_v_d = s2_v_q;

            if (in_valid) begin
                s1_d = s1_calc_s;
            end else if (CLEAR_ON_IDLE) begin
                s1_d = {(LANES*S1_W){1'b0}};
            end else begin
                s1_d = s1_q;
            end

            if (s1_v_q) begin
                s2_d = s2_calc_s;
            end else if (CLEAR_ON_IDLE) begin
                s2_d = {(LANES*S2_W){1'b0}};
            end else begin
                s2_d = s2_q;
            end

            if (s2_v_q) begin
                s3_d = s3_calc_s;
            end else if (CLEAR_ON_IDLE) begin
                s3_d = {(LANES*4){1'b0}};
            end else begin
                s3_d = s3_q;
            end
        end else begin
            s1_v_d = s1_v_q;
            s2_v_d = s2_v_q;
            s3_v_d = s3_v_q;
            s1_d   = s1_q;
            s2_d   = s2_q;
            s3_d   = s3_q;
        end
    end

    // Stage registers; reset drops every in-flight beat and clears all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            s1_q   <= {(LANES*S1_W){1'b0}};
            s2_q   <= {(LANES*S2_W){1'b0}};
            s3_q   <= {(LANES*4){1'b0}};
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            s3_v_q <= s3_v_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign in_ready  = en_s;
    assign out_valid = s3_v_q;
    assign Q         = s3_q;
    assign busy      = s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_gf_inv_4_masked_pipe.sv
// -----------------------------------------------------------------------------
// tb_gf_inv_4_masked_pipe
//
// Bench for gf_inv_4_masked_pipe with LANES=2, CLEAR_ON_IDLE=1.
// Golden inverse: brute-force search over an independently written GF(2^4)
// multiplier (GF(2^2) via discrete logs, tower constant nu = W^2), checked
// against a few hand-derived inverse pairs in the vector table.
// Expected results are queued when a beat is accepted and popped when the
// DUT retires a beat.
// -----------------------------------------------------------------------------
module tb_gf_inv_4_masked_pipe;

    localparam int LANES = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] M;
    logic [7:0] N;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Q;
    logic       busy;

    gf_inv_4_masked_pipe #(
        .LANES         (LANES),
        .CLEAR_ON_IDLE (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .M         (M),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] m;
        logic [7:0] n;
        logic [7:0] q;
    } beat_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_ret    = 0;
    logic       acc;
    logic       ret;
    logic [7:0] sb[$];
    logic [7:0] obs[$];
    beat_t      bq[$];
    beat_t      vecs[5];
    logic [3:0] inv_tbl[16];

    // ---------------- reference field arithmetic ----------------
    // GF(2^2) normal basis [W^2, W]: 11 = 1, 01 = W, 10 = W^2.
    function automatic int gf4_log(input logic [1:0] x);
        if (x == 2'b11) return 0;
        else if (x == 2'b01) return 1;
        else return 2;
    endfunction

    function automatic logic [1:0] gf4_mul_ref(input logic [1:0] x, input logic [1:0] y);
        int ls;
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        ls = (gf4_log(x) + gf4_log(y)) % 3;
        if (ls == 0) return 2'b11;
        else if (ls == 1) return 2'b01;
        else return 2'b10;
    endfunction

    // GF(2^4) over GF(2^2) with basis [Y^4, Y], Y^2 + Y + nu = 0, nu = W^2.
    function automatic logic [3:0] gf16_mul_ref(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] t;
        t = gf4_mul_ref(2'b10, gf4_mul_ref(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf4_mul_ref(x[3:2], y[3:2]) ^ t, gf4_mul_ref(x[1:0], y[1:0]) ^ t};
    endfunction

    function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] m, input logic [7:0] n);
        logic [7:0] x;
        x = a ^ m;
        return {inv_tbl[x[7:4]] ^ n[7:4], inv_tbl[x[3:0]] ^ n[3:0]};
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample the DUT.
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] m,
                        input logic [7:0] n, input logic [7:0] exp_q, input logic ordy);
        logic [7:0] e;
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        M         = m;
        N         = n;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        ret = out_valid & out_ready;
        if (ret) begin
            n_ret++;
            obs.push_back(Q);
            chk("sb_expected_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_q", 32'(Q), 32'(e));
            end
        end
        if (acc) sb.push_back(exp_q);
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && sb.size() != 0; k++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Stream every beat of bq back-to-back with out_ready high.
    task automatic run_stream(input bit chk_cont);
        int idx;
        int j;
        idx = 0;
        j   = 0;
        while (idx < bq.size() && j < bq.size() + 64) begin
            step(1'b1, bq[idx].a, bq[idx].m, bq[idx].n, bq[idx].q, 1'b1);
            if (chk_cont && j >= 3) chk("stream_out_valid_cont", 32'(out_valid), 32'd1);
            if (acc) idx++;
            j++;
        end
        chk("stream_all_accepted", 32'(idx), 32'(bq.size()));
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         sent;
        int         base;
        int         hist[16];
        logic       ordy;
        logic [11:0] iv12;
        logic [3:0]  xk;
        logic [7:0]  ra;
        logic [7:0]  rm;
        logic [7:0]  rn;

        // Vector table: lane1 in [7:4], lane0 in [3:0]; q derived by hand.
        vecs[0] = '{a: 8'h5F, m: 8'h50, n: 8'h30, q: 8'h3F}; // inv(F)=F, inv(0)=0
        vecs[1] = '{a: 8'h67, m: 8'h00, n: 8'h00, q: 8'h76}; // inv(7)=6, inv(6)=7
        vecs[2] = '{a: 8'h6E, m: 8'h39, n: 8'hC5, q: 8'h63}; // x=5,7 masked
        vecs[3] = '{a: 8'hC3, m: 8'h6F, n: 8'h1A, q: 8'h4B}; // x=A,C masked
        vecs[4] = '{a: 8'h05, m: 8'hF4, n: 8'hF0, q: 8'h0C}; // x=F,1 masked

        inv_tbl[0] = 4'h0;
        for (int x = 1; x < 16; x++) begin
            inv_tbl[x] = 4'h0;
            for (int y = 1; y < 16; y++) begin
                if (gf16_mul_ref(4'(x), 4'(y)) == 4'hF) inv_tbl[x] = 4'(y);
            end
        end

        // ---- reset then idle ----
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = 8'h00; M = 8'h00; N = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_q",         32'(Q),         32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'hA5, 8'h3C, 8'h96, 8'h00, 1'b1);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_busy",      32'(busy),      32'd0);
            chk("idle_q",         32'(Q),         32'd0);
            chk("idle_in_ready",  32'(in_ready),  32'd1);
        end

        // ---- identity and zero, single beat ----
        obs.delete();
        step(1'b1, vecs[0].a, vecs[0].m, vecs[0].n, vecs[0].q, 1'b1);
        chk("id_accept", 32'(acc), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            chk("id_valid_pulse", 32'(out_valid), 32'(k == 3));
        end
        chk("id_q_cleared_after", 32'(Q), 32'd0);
        chk("id_obs_count", 32'(obs.size()), 32'd1);
        drain();

        // ---- vector table back-to-back ----
        bq.delete();
        for (int k = 0; k < 5; k++) bq.push_back(vecs[k]);
        run_stream(1'b1);

        // ---- exhaustive (A,M,N) ----
        bq.delete();
        for (int i = 0; i < 4096; i++) begin
            iv12 = 12'(i);
            ra = {iv12[3:0],  iv12[11:8]};
            rm = {iv12[11:8], iv12[7:4]};
            rn = {iv12[7:4],  iv12[3:0]};
            bq.push_back('{a: ra, m: rm, n: rn, q: golden(ra, rm, rn)});
        end
        run_stream(1'b1);

        // ---- inv(inv(x)) = x through the DUT ----
        bq.delete();
        for (int x = 0; x < 16; x++) begin
            xk = 4'(x);
            bq.push_back('{a: {xk, xk}, m: 8'h00, n: 8'h00, q: {inv_tbl[xk], inv_tbl[xk]}});
        end
        obs.delete();
        run_stream(1'b0);
        chk("invinv_first_count", 32'(obs.size()), 32'd16);
        bq.delete();
        for (int k = 0; k < obs.size(); k++) begin
            xk = 4'(k);
            bq.push_back('{a: obs[k], m: 8'h00, n: 8'h00, q: {xk, xk}});
        end
        run_stream(1'b0);

        // ---- backpressure: out_ready low on cycles 4..6 ----
        sent = 0;
        base = n_ret;
        for (int j = 0; j < 15; j++) begin
            ordy = !(j >= 4 && j <= 6);
            if (sent < 5) step(1'b1, vecs[sent].a, vecs[sent].m, vecs[sent].n, vecs[sent].q, ordy);
            else          step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, ordy);
            if (j >= 4 && j <= 6) begin
                chk("bp_in_ready_low", 32'(in_ready),  32'd0);
                chk("bp_out_valid",    32'(out_valid), 32'd1);
                chk("bp_q_held",       32'(Q),         32'(vecs[1].q));
            end
            if (acc) sent++;
        end
        chk("bp_all_sent", 32'(sent),         32'd5);
        chk("bp_retired",  32'(n_ret - base), 32'd5);
        chk("bp_sb_empty", 32'(sb.size()),    32'd0);

        // ---- reset with three beats in flight ----
        for (int k = 0; k < 3; k++) begin
            step(1'b1, vecs[k+2].a, vecs[k+2].m, vecs[k+2].n, vecs[k+2].q, 1'b1);
        end
        chk("mid_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_q",         32'(Q),         32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        base = n_ret;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        chk("mid_rst_no_emerge", 32'(n_ret - base), 32'd0);

        // ---- mask independence: x = 7 in both lanes, random M and N ----
        bq.delete();
        for (int k = 0; k < 1000; k++) begin
            rm = 8'($urandom_range(0, 255));
            rn = 8'($urandom_range(0, 255));
            bq.push_back('{a: rm ^ 8'h77, m: rm, n: rn, q: rn ^ 8'h66});
        end
        obs.delete();
        run_stream(1'b1);
        for (int b = 0; b < 16; b++) hist[b] = 0;
        for (int k = 0; k < obs.size(); k++) hist[obs[k][3:0]]++;
        for (int b = 0; b < 16; b++) begin
            chk("mask_q_bin_populated", 32'(hist[b] >= 20), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
